// File: rtl/ahbl_mem_arb.sv
// ahbl_mem_arb: two-master AHB-lite arbiter in front of one memory controller.
//
// Master 0 (instruction side) and master 1 (data side) share one slave port.
// An uncontended request goes out to the slave in the same cycle it appears.
// A request that is sampled but cannot be issued yet is held in a one-entry
// pending buffer for that master. That master's hready stays low until the
// request is issued.
//
// Ports
//   clk, rst                  clock; synchronous active-high reset
//   m{0,1}_htrans/haddr/      master address phase
//     hwrite/hsize
//   m{0,1}_hwdata             master write data (data phase)
//   m{0,1}_hready/hrdata/     per-master response
//     hresp
//   s_htrans/haddr/hwrite/    shared slave request
//     hsize/hwdata
//   s_hready/hrdata/hresp     slave response
//
// Parameter RR_EN: 1 = round-robin on ties, 0 = fixed priority (M0 wins).
module ahbl_mem_arb #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  m0_htrans,
  input  logic [31:0] m0_haddr,
  input  logic        m0_hwrite,
  input  logic [2:0]  m0_hsize,
  input  logic [31:0] m0_hwdata,
  output logic        m0_hready,
  output logic [31:0] m0_hrdata,
  output logic        m0_hresp,
  input  logic [1:0]  m1_htrans,
  input  logic [31:0] m1_haddr,
  input  logic        m1_hwrite,
  input  logic [2:0]  m1_hsize,
  input  logic [31:0] m1_hwdata,
  output logic        m1_hready,
  output logic [31:0] m1_hrdata,
  output logic        m1_hresp,
  output logic [1:0]  s_htrans,
  output logic [31:0] s_haddr,
  output logic        s_hwrite,
  output logic [2:0]  s_hsize,
  output logic [31:0] s_hwdata,
  input  logic        s_hready,
  input  logic [31:0] s_hrdata,
  input  logic        s_hresp
);

  typedef enum logic [1:0] {OWN_NONE = 2'd0, OWN_M0 = 2'd1, OWN_M1 = 2'd2} owner_e;

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;

  // Pending buffers: one entry per master.
  logic        r_p0_vld, r_p1_vld;
  logic [31:0] r_p0_addr, r_p1_addr;
  logic        r_p0_write, r_p1_write;
  logic [2:0]  r_p0_size, r_p1_size;

  owner_e      r_dp_owner, w_dp_owner_nxt;
  logic        r_last_grant;          // 0 = M0, 1 = M1

  logic        w_m0_live, w_m1_live;
  logic        w_c0, w_c1;
  logic        w_issue;
  logic        w_grant;               // 0 = M0, 1 = M1

  // Per-master ready. A pending master is held off. The data-phase owner
  // follows the slave. Everyone else is idle and ready.
  assign m0_hready = r_p0_vld ? 1'b0 : (r_dp_owner == OWN_M0) ? s_hready : 1'b1;
  assign m1_hready = r_p1_vld ? 1'b0 : (r_dp_owner == OWN_M1) ? s_hready : 1'b1;

  assign m0_hrdata = (r_dp_owner == OWN_M0) ? s_hrdata : 32'h0;
  assign m1_hrdata = (r_dp_owner == OWN_M1) ? s_hrdata : 32'h0;
  assign m0_hresp  = (r_dp_owner == OWN_M0) ? s_hresp  : 1'b0;
  assign m1_hresp  = (r_dp_owner == OWN_M1) ? s_hresp  : 1'b0;

  // htrans[1] set means NONSEQ/SEQ. It is only sampled while hready is high.
  assign w_m0_live = m0_htrans[1] & m0_hready;
  assign w_m1_live = m1_htrans[1] & m1_hready;

  assign w_c0 = r_p0_vld | w_m0_live;
  assign w_c1 = r_p1_vld | w_m1_live;

  // Reset gates the issue so that an in-flight request never reaches the slave.
  assign w_issue = ~rst & s_hready & (w_c0 | w_c1);

  always_comb begin
    w_grant = 1'b0;
    if (w_c0 && w_c1) begin
      if (RR_EN) w_grant = ~r_last_grant;
      else       w_grant = 1'b0;
    end else begin
      w_grant = ~w_c0;
    end
  end

  always_comb begin
    s_htrans = HT_IDLE;
    s_haddr  = 32'h0;
    s_hwrite = 1'b0;
    s_hsize  = 3'h0;
    if (w_issue) begin
      s_htrans = HT_NONSEQ;
      if (w_grant) begin
        s_haddr  = r_p1_vld ? r_p1_addr  : m1_haddr;
        s_hwrite = r_p1_vld ? r_p1_write : m1_hwrite;
        s_hsize  = r_p1_vld ? r_p1_size  : m1_hsize;
      end else begin
        s_haddr  = r_p0_vld ? r_p0_addr  : m0_haddr;
        s_hwrite = r_p0_vld ? r_p0_write : m0_hwrite;
        s_hsize  = r_p0_vld ? r_p0_size  : m0_hsize;
      end
    end
  end

  always_comb begin
    s_hwdata = 32'h0;
    case (r_dp_owner)
      OWN_M0:  s_hwdata = m0_hwdata;
      OWN_M1:  s_hwdata = m1_hwdata;
      default: s_hwdata = 32'h0;
    endcase
  end

  // Data-phase owner: it moves only when the slave completes the current
  // phase (s_hready=1).
  always_comb begin
    w_dp_owner_nxt = r_dp_owner;
    if (s_hready) begin
      if (w_issue) w_dp_owner_nxt = w_grant ? OWN_M1 : OWN_M0;
      else         w_dp_owner_nxt = OWN_NONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_dp_owner <= OWN_NONE;
    else     r_dp_owner <= w_dp_owner_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_p0_vld     <= 1'b0;
      r_p0_addr    <= 32'h0;
      r_p0_write   <= 1'b0;
      r_p0_size    <= 3'h0;
      r_p1_vld     <= 1'b0;
      r_p1_addr    <= 32'h0;
      r_p1_write   <= 1'b0;
      r_p1_size    <= 3'h0;
      r_last_grant <= 1'b1;
    end else begin
      if (w_issue && !w_grant) begin
        r_p0_vld <= 1'b0;
      end else if (w_m0_live) begin
        r_p0_vld   <= 1'b1;
        r_p0_addr  <= m0_haddr;
        r_p0_write <= m0_hwrite;
        r_p0_size  <= m0_hsize;
      end
      if (w_issue && w_grant) begin
        r_p1_vld <= 1'b0;
      end else if (w_m1_live) begin
        r_p1_vld   <= 1'b1;
        r_p1_addr  <= m1_haddr;
        r_p1_write <= m1_hwrite;
        r_p1_size  <= m1_hsize;
      end
      if (w_issue) r_last_grant <= w_grant;
    end
  end

  // A live request must never be sampled over an occupied pending entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_p0_vld && w_m0_live));
      assert (!(r_p1_vld && w_m1_live));
    end
  end

endmodule
